// File: rtl/sram_pipe_if.sv
// sram_pipe_if: Octree-side memory port bundle for sram_pipe.
//   master : drives CEN/A/D/GWEN/BWEN (active-low strobes), observes responses
//   slave  : the memory model; drives Q/QV/ERR/err_cnt/init_busy
// Signals keep the original mem_sram_* names so the bundle maps one-to-one
// onto the legacy port list.
interface sram_pipe_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LANE_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 64
);
    localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;

    logic                  mem_sram_CEN;   // chip enable, active-low
    logic [ADDR_WIDTH-1:0] mem_sram_A;     // word address
    logic [DATA_WIDTH-1:0] mem_sram_D;     // write data
    logic                  mem_sram_GWEN;  // 0 = write, 1 = read
    logic [LANES-1:0]      mem_sram_BWEN;  // per-lane write enable, active-low
    logic [DATA_WIDTH-1:0] mem_sram_Q;     // read data (held while QV=0)
    logic                  mem_sram_QV;    // read-data-valid pulse
    logic                  mem_sram_ERR;   // out-of-range pulse
    logic [15:0]           err_cnt;        // saturating out-of-range count
    logic                  init_busy;      // zero-fill sweep in progress

    modport master (
        output mem_sram_CEN, mem_sram_A, mem_sram_D, mem_sram_GWEN, mem_sram_BWEN,
        input  mem_sram_Q, mem_sram_QV, mem_sram_ERR, err_cnt, init_busy
    );

    modport slave (
        input  mem_sram_CEN, mem_sram_A, mem_sram_D, mem_sram_GWEN, mem_sram_BWEN,
        output mem_sram_Q, mem_sram_QV, mem_sram_ERR, err_cnt, init_busy
    );
endinterface

// File: rtl/sram_pipe.sv
// sram_pipe: single-port SRAM model for the Octree memory port.
//   - per-lane write masking (BWEN, active-low)
//   - READ_LATENCY-deep (1..4) fully pipelined read path
//   - address window [BASE_ADDR, BASE_ADDR+MEM_DEPTH) with ERR pulse and
//     saturating err_cnt
//   - optional zero-fill sweep after reset, enabled by defining
//     SRAM_PIPE_ZERO_INIT_EN; otherwise init_busy is tied low and the array
//     is never initialised.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   bus : sram_pipe_if.slave (mem_sram_CEN/A/D/GWEN/BWEN in,
//         mem_sram_Q/QV/ERR, err_cnt, init_busy out)
module sram_pipe #(
    parameter int unsigned     DATA_WIDTH   = 64,
    parameter int unsigned     LANE_WIDTH   = 16,
    parameter int unsigned     ADDR_WIDTH   = 64,
    parameter int unsigned     MEM_DEPTH    = 20280,
    parameter longint unsigned BASE_ADDR    = 0,
    parameter int unsigned     READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    sram_pipe_if.slave    bus
);
    localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  init_busy;
    logic                  sweep_we;
    logic [IDX_W-1:0]      sweep_ptr;

    logic [ADDR_WIDTH-1:0] off;
    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  access;
    logic                  wr_en;
    logic                  rd_req;
    logic                  req_err;

    // Read pipeline: stage READ_LATENCY-1 is the output register.
    logic [READ_LATENCY-1:0] pv_q;
    logic [READ_LATENCY-1:0] pe_q;
    logic [DATA_WIDTH-1:0]   pd_q [READ_LATENCY];
    logic                    last_err_in;
    logic [15:0]             err_cnt_q;
    logic [15:0]             err_cnt_d;

    // ------------------------------------------------------------------
    // Optional zero-fill sweep
    // ------------------------------------------------------------------
`ifdef SRAM_PIPE_ZERO_INIT_EN
    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sweep_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                // The sweep only writes once rst has been released.
                sweep_we = !rst;
                if (ptr_q == IDX_W'(MEM_DEPTH - 1)) begin
                    state_d = ST_READY;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign init_busy = (state_q == ST_INIT);
    assign sweep_ptr = ptr_q;
`else
    assign init_busy = 1'b0;
    assign sweep_we  = 1'b0;
    assign sweep_ptr = '0;
`endif

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign off      = bus.mem_sram_A - BASE_A;
    assign idx      = off[IDX_W-1:0];
    assign in_range = (bus.mem_sram_A >= BASE_A) && (off < DEPTH_A);
    assign access   = !bus.mem_sram_CEN && !rst && !init_busy;
    assign wr_en    = access && !bus.mem_sram_GWEN && in_range;
    assign rd_req   = access && bus.mem_sram_GWEN;
    assign req_err  = access && !in_range;

    // ------------------------------------------------------------------
    // Storage: zero-fill and normal writes never coincide because
    // accesses are blocked while init_busy is high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_ptr] <= '0;
        end else if (wr_en) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (!bus.mem_sram_BWEN[l]) begin
                    mem[idx][l*LANE_WIDTH +: LANE_WIDTH] <= bus.mem_sram_D[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Data stages only advance on a valid entry, so the
    // output stage naturally holds the last returned word while QV=0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
            pe_q <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pd_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= rd_req;
            pe_q[0] <= req_err;
            if (rd_req) begin
                pd_q[0] <= in_range ? mem[idx] : '0;
            end
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pe_q[i] <= pe_q[i-1];
                if (pv_q[i-1]) begin
                    pd_q[i] <= pd_q[i-1];
                end
            end
        end
    end

    // Error bit about to enter the output stage; counting it here keeps
    // err_cnt aligned with the ERR pulse.
    if (READ_LATENCY == 1) begin : g_err_l1
        assign last_err_in = req_err;
    end else begin : g_err_ln
        assign last_err_in = pe_q[READ_LATENCY-2];
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (last_err_in && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.mem_sram_Q   = pd_q[READ_LATENCY-1];
    assign bus.mem_sram_QV  = pv_q[READ_LATENCY-1];
    assign bus.mem_sram_ERR = pe_q[READ_LATENCY-1];
    assign bus.err_cnt      = err_cnt_q;
    assign bus.init_busy    = init_busy;
endmodule

// File: tb/tb_sram_pipe.sv
// tb_sram_pipe: directed, table-driven bench for sram_pipe.
// Three instances share one stimulus bus:
//   u1 : READ_LATENCY=1, BASE_ADDR=0,   MEM_DEPTH=32
//   u3 : READ_LATENCY=3, BASE_ADDR=0,   MEM_DEPTH=32
//   u2 : READ_LATENCY=2, BASE_ADDR=400, MEM_DEPTH=16
// Each test starts from reset so err_cnt and pipelines start clean.
module tb_sram_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        gwen = 1'b1;
    logic [63:0] a = '0;
    logic [63:0] d = '0;
    logic [3:0]  bwen = 4'hF;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_pipe_if #(.DATA_WIDTH(64), .LANE_WIDTH(16), .ADDR_WIDTH(64)) bus1 ();
    sram_pipe_if #(.DATA_WIDTH(64), .LANE_WIDTH(16), .ADDR_WIDTH(64)) bus2 ();
    sram_pipe_if #(.DATA_WIDTH(64), .LANE_WIDTH(16), .ADDR_WIDTH(64)) bus3 ();

    assign bus1.mem_sram_CEN = cen;  assign bus2.mem_sram_CEN = cen;  assign bus3.mem_sram_CEN = cen;
    assign bus1.mem_sram_A = a;      assign bus2.mem_sram_A = a;      assign bus3.mem_sram_A = a;
    assign bus1.mem_sram_D = d;      assign bus2.mem_sram_D = d;      assign bus3.mem_sram_D = d;
    assign bus1.mem_sram_GWEN = gwen; assign bus2.mem_sram_GWEN = gwen; assign bus3.mem_sram_GWEN = gwen;
    assign bus1.mem_sram_BWEN = bwen; assign bus2.mem_sram_BWEN = bwen; assign bus3.mem_sram_BWEN = bwen;

    sram_pipe #(.DATA_WIDTH(64), .LANE_WIDTH(16), .ADDR_WIDTH(64), .MEM_DEPTH(32),
                .BASE_ADDR(0), .READ_LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    sram_pipe #(.DATA_WIDTH(64), .LANE_WIDTH(16), .ADDR_WIDTH(64), .MEM_DEPTH(16),
                .BASE_ADDR(400), .READ_LATENCY(2)) u2 (.clk(clk), .rst(rst), .bus(bus2));
    sram_pipe #(.DATA_WIDTH(64), .LANE_WIDTH(16), .ADDR_WIDTH(64), .MEM_DEPTH(32),
                .BASE_ADDR(0), .READ_LATENCY(3)) u3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        logic        cen;
        logic        gwen;
        logic [63:0] a;
        logic [63:0] d;
        logic [3:0]  bwen;
        logic        qv;
        logic        err;
        logic [63:0] q;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl1 [14];
    vec_t tbl2 [6];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic g, input logic [63:0] aa,
                         input logic [63:0] dd, input logic [3:0] bw);
        cen = c; gwen = g; a = aa; d = dd; bwen = bw;
    endtask

    task automatic wait_ready();
        int n = 0;
        while ((bus1.init_busy | bus2.init_busy | bus3.init_busy) && n < 200) begin
            step();
            n++;
        end
        chk("init_done", {61'b0, bus1.init_busy, bus2.init_busy, bus3.init_busy}, 64'd0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 64'd0, 64'd0, 4'hF);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        wait_ready();
    endtask

    // Applies one vector and compares the selected instance's outputs one
    // cycle later (next negedge).
    task automatic apply(input vec_t v, input int which, input string tag);
        logic        qv, er;
        logic [63:0] q;
        logic [15:0] cnt;
        drive(v.cen, v.gwen, v.a, v.d, v.bwen);
        step();
        if (which == 1) begin
            qv = bus1.mem_sram_QV; er = bus1.mem_sram_ERR; q = bus1.mem_sram_Q; cnt = bus1.err_cnt;
        end else begin
            qv = bus2.mem_sram_QV; er = bus2.mem_sram_ERR; q = bus2.mem_sram_Q; cnt = bus2.err_cnt;
        end
        chk({tag, ".qv"}, qv, v.qv);
        chk({tag, ".err"}, er, v.err);
        chk({tag, ".q"}, q, v.q);
        chk({tag, ".cnt"}, cnt, v.cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // u1 (latency 1): response to vector i is checked right after its edge.
        //          cen   gwen  a        d                       bwen     qv    err   q                       cnt
        tbl1[0]  = '{1'b0, 1'b0, 64'd5,   64'h1111_2222_3333_4444, 4'b0000, 1'b0, 1'b0, 64'h0,                  16'd0};
        tbl1[1]  = '{1'b0, 1'b1, 64'd5,   64'h0,                  4'b1111, 1'b1, 1'b0, 64'h1111_2222_3333_4444, 16'd0};
        tbl1[2]  = '{1'b1, 1'b1, 64'd0,   64'h0,                  4'b1111, 1'b0, 1'b0, 64'h1111_2222_3333_4444, 16'd0};
        tbl1[3]  = '{1'b0, 1'b0, 64'd5,   64'hAAAA_BBBB_CCCC_DDDD, 4'b1010, 1'b0, 1'b0, 64'h1111_2222_3333_4444, 16'd0};
        tbl1[4]  = '{1'b0, 1'b1, 64'd5,   64'h0,                  4'b1111, 1'b1, 1'b0, 64'h1111_BBBB_3333_DDDD, 16'd0};
        tbl1[5]  = '{1'b0, 1'b0, 64'd6,   64'h0123_4567_89AB_CDEF, 4'b0000, 1'b0, 1'b0, 64'h1111_BBBB_3333_DDDD, 16'd0};
        tbl1[6]  = '{1'b0, 1'b1, 64'd6,   64'h0,                  4'b1111, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 16'd0};
        tbl1[7]  = '{1'b0, 1'b0, 64'd6,   64'hFFFF_FFFF_FFFF_FFFF, 4'b1111, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 16'd0};
        tbl1[8]  = '{1'b0, 1'b1, 64'd6,   64'h0,                  4'b1111, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 16'd0};
        tbl1[9]  = '{1'b0, 1'b1, 64'd32,  64'h0,                  4'b1111, 1'b1, 1'b1, 64'h0,                  16'd1};
        tbl1[10] = '{1'b0, 1'b0, 64'd37,  64'h5555_5555_5555_5555, 4'b0000, 1'b0, 1'b1, 64'h0,                  16'd2};
        tbl1[11] = '{1'b0, 1'b0, 64'd31,  64'hDEAD_BEEF_0000_0001, 4'b0000, 1'b0, 1'b0, 64'h0,                  16'd2};
        tbl1[12] = '{1'b0, 1'b1, 64'd31,  64'h0,                  4'b1111, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 16'd2};
        tbl1[13] = '{1'b0, 1'b1, 64'd5,   64'h0,                  4'b1111, 1'b1, 1'b0, 64'h1111_BBBB_3333_DDDD, 16'd2};

        // u2 (latency 2, window 400..415): outputs after edge k show request k-1.
        tbl2[0]  = '{1'b0, 1'b0, 64'd400, 64'h4004_0000_0000_0400, 4'b0000, 1'b0, 1'b0, 64'h0,                  16'd0};
        tbl2[1]  = '{1'b0, 1'b1, 64'd399, 64'h0,                  4'b1111, 1'b0, 1'b0, 64'h0,                  16'd0};
        tbl2[2]  = '{1'b0, 1'b0, 64'd416, 64'hBAD0_BAD0_BAD0_BAD0, 4'b0000, 1'b1, 1'b1, 64'h0,                  16'd1};
        tbl2[3]  = '{1'b0, 1'b1, 64'd400, 64'h0,                  4'b1111, 1'b0, 1'b1, 64'h0,                  16'd2};
        tbl2[4]  = '{1'b1, 1'b1, 64'd0,   64'h0,                  4'b1111, 1'b1, 1'b0, 64'h4004_0000_0000_0400, 16'd2};
        tbl2[5]  = '{1'b1, 1'b1, 64'd0,   64'h0,                  4'b1111, 1'b0, 1'b0, 64'h4004_0000_0000_0400, 16'd2};

        @(negedge clk);
        do_reset();

        // Reset state of every instance
        chk("rst.u1.q",   bus1.mem_sram_Q, 64'd0);
        chk("rst.u1.qv",  bus1.mem_sram_QV, 64'd0);
        chk("rst.u1.err", bus1.mem_sram_ERR, 64'd0);
        chk("rst.u1.cnt", bus1.err_cnt, 64'd0);
        chk("rst.u2.q",   bus2.mem_sram_Q, 64'd0);
        chk("rst.u2.qv",  bus2.mem_sram_QV, 64'd0);
        chk("rst.u2.cnt", bus2.err_cnt, 64'd0);
        chk("rst.u3.q",   bus3.mem_sram_Q, 64'd0);
        chk("rst.u3.qv",  bus3.mem_sram_QV, 64'd0);
        chk("rst.u3.err", bus3.mem_sram_ERR, 64'd0);

        // Latency-1 functional table
        for (int i = 0; i < 14; i++) begin
            apply(tbl1[i], 1, $sformatf("u1v%0d", i));
        end

        // Latency-3 back-to-back reads
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 64'(k), 64'hC0DE_0000_0000_0000 + 64'(k), 4'b0000);
            step();
        end
        for (int k = 0; k < 6; k++) begin
            logic        eqv;
            logic [63:0] eq;
            if (k < 3) drive(1'b0, 1'b1, 64'(k), 64'd0, 4'hF);
            else       drive(1'b1, 1'b1, 64'd0, 64'd0, 4'hF);
            step();
            eqv = (k >= 2 && k <= 4);
            if (k < 2)      eq = 64'd0;
            else if (k < 4) eq = 64'hC0DE_0000_0000_0000 + 64'(k - 2);
            else            eq = 64'hC0DE_0000_0000_0002;
            chk($sformatf("lat3.k%0d.qv", k), bus3.mem_sram_QV, 64'(eqv));
            chk($sformatf("lat3.k%0d.q", k), bus3.mem_sram_Q, eq);
        end

        // Address window on u2
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(tbl2[i], 2, $sformatf("u2v%0d", i));
        end

        // Reset with reads in flight
        do_reset();
        drive(1'b0, 1'b1, 64'd0, 64'd0, 4'hF);
        step();
        chk("flush.e0.u3qv", bus3.mem_sram_QV, 64'd0);
        drive(1'b0, 1'b1, 64'd1, 64'd0, 4'hF);
        step();
        chk("flush.e1.u3qv", bus3.mem_sram_QV, 64'd0);
        drive(1'b1, 1'b1, 64'd0, 64'd0, 4'hF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("flush.rst.u1qv", bus1.mem_sram_QV, 64'd0);
        chk("flush.rst.u2qv", bus2.mem_sram_QV, 64'd0);
        chk("flush.rst.u2cnt", bus2.err_cnt, 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("flush.k%0d.u3qv", k), bus3.mem_sram_QV, 64'd0);
            chk($sformatf("flush.k%0d.u2qv", k), bus2.mem_sram_QV, 64'd0);
        end
        wait_ready();
        chk("flush.u2cnt", bus2.err_cnt, 64'd0);
        chk("flush.u3cnt", bus3.err_cnt, 64'd0);

`ifdef SRAM_PIPE_ZERO_INIT_EN
        // Zero-fill sweep on u2 (depth 16)
        begin
            int n = 0;
            drive(1'b0, 1'b0, 64'd407, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000);
            step();
            drive(1'b1, 1'b1, 64'd0, 64'd0, 4'hF);
            rst = 1'b1;
            step();
            step();
            rst = 1'b0;
            drive(1'b0, 1'b1, 64'd400, 64'd0, 4'hF);
            while (bus2.init_busy && n < 100) begin
                chk($sformatf("zi.busy%0d.qv", n), bus2.mem_sram_QV, 64'd0);
                chk($sformatf("zi.busy%0d.err", n), bus2.mem_sram_ERR, 64'd0);
                n++;
                step();
            end
            drive(1'b1, 1'b1, 64'd0, 64'd0, 4'hF);
            chk("zi.busy_cycles", 64'(n), 64'd16);
            step();
            chk("zi.post1.qv", bus2.mem_sram_QV, 64'd0);
            step();
            chk("zi.post2.qv", bus2.mem_sram_QV, 64'd0);
            wait_ready();
            drive(1'b0, 1'b1, 64'd407, 64'd0, 4'hF);
            step();
            drive(1'b1, 1'b1, 64'd0, 64'd0, 4'hF);
            step();
            chk("zi.rd407.qv", bus2.mem_sram_QV, 64'd1);
            chk("zi.rd407.q", bus2.mem_sram_Q, 64'd0);
            chk("zi.rd407.err", bus2.mem_sram_ERR, 64'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_pipe.md
# sram_pipe

Parametrised single-port SRAM model that replaces the fixed-latency memory beside `Octree` in simulation and FPGA builds. It keeps the `mem_sram_*` active-low strobe convention and adds the following:
- per-lane write masking;
- configurable read latency, fully pipelined;
- an address window with out-of-range error reporting;
- optional zero-fill after reset.

It sits directly on the Octree memory port and services one access per cycle.

## Interface
- `DATA_WIDTH`, 64: word width; must be a multiple of `LANE_WIDTH`.
- `LANE_WIDTH`, 16: write-mask granularity; `LANES = DATA_WIDTH/LANE_WIDTH`.
- `ADDR_WIDTH`, 64: address bus width.
- `MEM_DEPTH`, 20280: number of words.
- `BASE_ADDR`, 0: first valid address.
- `READ_LATENCY`, 1: cycles from request to data; legal range 1..4.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `mem_sram_CEN`  in  1  chip enable, active-low.
- `mem_sram_A`  in  ADDR_WIDTH  word address.
- `mem_sram_D`  in  DATA_WIDTH  write data.
- `mem_sram_GWEN`  in  1  global write enable, active-low (0 = write, 1 = read).
- `mem_sram_BWEN`  in  LANES  per-lane write enable, active-low; bit i covers `D[i*LANE_WIDTH +: LANE_WIDTH]`.
- `mem_sram_Q`  out  DATA_WIDTH  read data.
- `mem_sram_QV`  out  1  read-data-valid pulse.
- `mem_sram_ERR`  out  1  out-of-range pulse.
- `err_cnt`  out  16  saturating count of out-of-range accesses.
- `init_busy`  out  1  zero-fill in progress.

## Operation
- An access occurs at a rising edge where `CEN=0`, `rst=0` and `init_busy=0`.
- Address check: `off = A - BASE_ADDR`, computed at ADDR_WIDTH bits. The address is in range iff `A >= BASE_ADDR && off < MEM_DEPTH`.
- Write (`GWEN=0`, in range): lanes with `BWEN[i]=0` are updated at that edge; other lanes keep their contents. If `BWEN` is all ones, nothing is written and no error is raised.
- Read (`GWEN=1`, in range): `mem[off]` is captured at the request edge. It travels a `READ_LATENCY`-deep pipeline together with a valid bit and an error bit.
- Out-of-range write: memory is unchanged. `ERR` pulses and `err_cnt` increments, aligned like a read response. `QV` stays 0.
- Out-of-range read: returns `Q = 0` with `QV = 1` and `ERR = 1` in the same cycle. `err_cnt` increments.
- `err_cnt` saturates at 0xFFFF and clears only on `rst`.
- `Q` holds its last value in cycles where `QV = 0`.
- Read-after-write to the same address in the next cycle returns the new data. Single port, so simultaneous read and write cannot occur.

## Timing
- A request sampled at edge t drives `QV`/`Q`/`ERR` during the cycle after edge `t+READ_LATENCY-1`. With `READ_LATENCY=1` this is classic next-cycle SRAM data.
- Throughput is one access per cycle. Back-to-back reads give back-to-back `QV`.
- Reset values: `Q=0`, `QV=0`, `ERR=0`, `err_cnt=0`, all pipeline valid bits 0.
  - `init_busy` resets to 1 with the macro defined and to 0 without it.
- Reset mid-operation: in-flight reads are discarded and no `QV` is produced for them. Memory contents are untouched, except for the zero-fill below.
- Accesses while `init_busy=1` are ignored: no write, no `QV`, no `ERR`, not counted.

## Configuration
- `SRAM_PIPE_ZERO_INIT_EN` defined: a two-state FSM, INIT then READY.
  - INIT is entered on `rst`, with the sweep pointer at 0.
  - After `rst` deasserts, one word per cycle is written to zero at the pointer, `MEM_DEPTH` cycles in total; `init_busy=1` throughout.
  - When the pointer reaches `MEM_DEPTH-1`, the FSM moves to READY and `init_busy` falls on the following cycle.
  - `rst` asserted during INIT restarts the sweep from 0.
- Not defined: no FSM, `init_busy` is tied to 0, and memory contents are never initialised (X until written).

## Test plan
- Write `A=5, D=64'h1111_2222_3333_4444, BWEN=4'b0000`, then read `A=5` with `READ_LATENCY=1` -> `Q=64'h1111_2222_3333_4444`, `QV=1` exactly one cycle after the read edge.
- Masked write `A=5, D=64'hAAAA_BBBB_CCCC_DDDD, BWEN=4'b1010`, then read `A=5` -> `Q=64'h1111_BBBB_3333_DDDD`.
- `READ_LATENCY=3`, reads of `A=0,1,2` on consecutive edges -> three consecutive `QV` cycles starting three cycles after the first request, with data in order.
- `BASE_ADDR=400`: read `A=399`, then write `A=400+MEM_DEPTH` -> both produce `ERR=1` and `err_cnt=2`; the read gives `QV=1, Q=0`; memory is unchanged.
- Assert `rst` with two reads in flight (`READ_LATENCY=2`) -> no `QV` follows; `err_cnt=0`.
- With `SRAM_PIPE_ZERO_INIT_EN`, `MEM_DEPTH=16`: after `rst`, `init_busy` stays high 16 cycles; a read of `A=7` then returns 0. A read issued while busy returns no `QV`.
